// File: rtl/spi_master_shifter.sv
// SPI mode-0 master serial engine between a TX FIFO and an RX FIFO.
// Pops words, shifts them out full duplex on sclk/mosi/miso, and pushes each received word.
module spi_master_shifter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             enable,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_empty,
    output logic             tx_rd_en,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_wr_en,
    input  logic             rx_full,
    output logic             rx_overflow,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             cs_n,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned HC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [HC_W-1:0]  HALF_RELOAD = HC_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StShift,
        StHold
    } state_e;

    state_e           state;
    logic [HC_W-1:0]  half_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;

    logic             can_start;
    logic             half_done;
    logic             load_bit;
    logic             next_bit;
    logic [WIDTH-1:0] tx_shifted;
    logic [WIDTH-1:0] rx_shifted;

    assign can_start = enable && !tx_empty && !rx_full;
    assign half_done = (half_cnt == '0);

    // Bit ordering is resolved here so the state machine stays order-agnostic.
    always_comb begin
        tx_shifted = '0;
        rx_shifted = '0;
        load_bit   = 1'b0;
        next_bit   = 1'b0;
        if (MSB_FIRST != 0) begin
            tx_shifted = {tx_sr[WIDTH-2:0], 1'b0};
            rx_shifted = {rx_sr[WIDTH-2:0], miso};
            load_bit   = tx_data[WIDTH-1];
            next_bit   = tx_sr[WIDTH-2];
        end else begin
            tx_shifted = {1'b0, tx_sr[WIDTH-1:1]};
            rx_shifted = {miso, rx_sr[WIDTH-1:1]};
            load_bit   = tx_data[0];
            next_bit   = tx_sr[1];
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state       <= StIdle;
            half_cnt    <= '0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            tx_rd_en    <= 1'b0;
            rx_data     <= '0;
            rx_wr_en    <= 1'b0;
            rx_overflow <= 1'b0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            cs_n        <= 1'b1;
            busy        <= 1'b0;
        end else begin
            tx_rd_en <= 1'b0;
            rx_wr_en <= 1'b0;

            case (state)
                StIdle: begin
                    if (can_start) begin
                        state    <= StFetch;
                        tx_rd_en <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                // FIFO dout becomes valid during LOAD, one cycle after the pop.
                StFetch: begin
                    state <= StLoad;
                end

                StLoad: begin
                    tx_sr    <= tx_data;
                    mosi     <= load_bit;
                    cs_n     <= 1'b0;
                    half_cnt <= HALF_RELOAD;
                    bit_cnt  <= '0;
                    state    <= StShift;
                end

                StShift: begin
                    if (!half_done) begin
                        half_cnt <= half_cnt - 1'b1;
                    end else begin
                        half_cnt <= HALF_RELOAD;
                        sclk     <= ~sclk;
                        if (!sclk) begin
                            rx_sr <= rx_shifted;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                rx_data     <= rx_sr;
                                rx_wr_en    <= 1'b1;
                                rx_overflow <= rx_overflow | rx_full;
                                if (can_start) begin
                                    state    <= StFetch;
                                    tx_rd_en <= 1'b1;
                                end else begin
                                    state <= StHold;
                                end
                            end else begin
                                tx_sr <= tx_shifted;
                                mosi  <= next_bit;
                            end
                        end
                    end
                end

                // half_cnt was reloaded on the final falling edge, giving CLK_DIV cycles here.
                StHold: begin
                    if (half_done) begin
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed bench for spi_master_shifter: an MSB-first loopback instance and an LSB-first instance.
module tb_spi_master_shifter;

    logic       clk = 1'b0;
    logic       srst;
    logic       enable;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       tx_rd_en;
    logic [7:0] rx_data;
    logic       rx_wr_en;
    logic       rx_full;
    logic       rx_overflow;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;
    logic       busy;

    logic       b_enable;
    logic [7:0] b_tx_data;
    logic       b_tx_empty;
    logic       b_tx_rd_en;
    logic [7:0] b_rx_data;
    logic       b_rx_wr_en;
    logic       b_rx_full;
    logic       b_rx_overflow;
    logic       b_sclk;
    logic       b_mosi;
    logic       b_miso;
    logic       b_cs_n;
    logic       b_busy;

    always #5 clk = ~clk;

    spi_master_shifter #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1)) dut (
        .clk(clk), .srst(srst), .enable(enable), .tx_data(tx_data), .tx_empty(tx_empty),
        .tx_rd_en(tx_rd_en), .rx_data(rx_data), .rx_wr_en(rx_wr_en), .rx_full(rx_full),
        .rx_overflow(rx_overflow), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n),
        .busy(busy)
    );

    spi_master_shifter #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .srst(srst), .enable(b_enable), .tx_data(b_tx_data),
        .tx_empty(b_tx_empty), .tx_rd_en(b_tx_rd_en), .rx_data(b_rx_data),
        .rx_wr_en(b_rx_wr_en), .rx_full(b_rx_full), .rx_overflow(b_rx_overflow),
        .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso), .cs_n(b_cs_n), .busy(b_busy)
    );

    // TX FIFO model: array written by the stimulus, read pointer advanced on each pop.
    logic [7:0] tx_mem [16];
    int         push_cnt = 0;
    int         pop_cnt = 0;

    assign tx_empty = (push_cnt == pop_cnt);
    assign miso     = mosi;

    always @(posedge clk) begin
        if (tx_rd_en) begin
            tx_data <= tx_mem[pop_cnt[3:0]];
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Cumulative monitors, sampled on the falling clk edge.
    int         cyc = 0;
    int         rises = 0;
    int         rd_cnt = 0;
    int         cs_rises = 0;
    int         cs_fall_cyc = 0;
    int         bad_pop = 0;
    logic       sclk_prev = 1'b0;
    logic       cs_prev = 1'b1;
    logic       mosi_bits [$];
    int         rise_cyc [$];
    logic [7:0] rx_q [$];
    int         wr_cyc [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sclk && !sclk_prev) begin
            rises = rises + 1;
            mosi_bits.push_back(mosi);
            rise_cyc.push_back(cyc);
        end
        if (tx_rd_en) rd_cnt = rd_cnt + 1;
        if (tx_rd_en && tx_empty) bad_pop = bad_pop + 1;
        if (rx_wr_en) begin
            rx_q.push_back(rx_data);
            wr_cyc.push_back(cyc);
        end
        if (cs_n && !cs_prev) cs_rises = cs_rises + 1;
        if (!cs_n && cs_prev) cs_fall_cyc = cyc;
        sclk_prev = sclk;
        cs_prev   = cs_n;
    end

    // LSB-first instance monitors; miso follows an 8-bit pattern indexed by sclk rises seen.
    logic [7:0] b_pat = 8'h01;
    int         b_rises = 0;
    int         b_rd_cnt = 0;
    int         b_rx_cnt = 0;
    logic [7:0] b_seq = 8'h00;
    logic [7:0] b_rx_last = 8'h00;
    logic       b_first = 1'b1;
    logic       b_sclk_prev = 1'b0;

    assign b_miso = b_pat[b_rises[2:0]];

    always @(negedge clk) begin
        if (b_sclk && !b_sclk_prev) begin
            if (b_rises == 0) b_first = b_mosi;
            b_seq   = {b_seq[6:0], b_mosi};
            b_rises = b_rises + 1;
        end
        if (b_tx_rd_en) b_rd_cnt = b_rd_cnt + 1;
        if (b_rx_wr_en) begin
            b_rx_cnt  = b_rx_cnt + 1;
            b_rx_last = b_rx_data;
        end
        b_sclk_prev = b_sclk;
    end

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] w);
        tx_mem[push_cnt[3:0]] = w;
        push_cnt = push_cnt + 1;
    endtask

    task automatic wait_done(input int n_rx, input string tag);
        int k = 0;
        while (rx_q.size() < n_rx && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rx_arrived"}, (rx_q.size() >= n_rx), 1);
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, busy, 0);
        @(negedge clk);
    endtask

    function automatic logic [15:0] mosi_seq(input int from, input int n);
        logic [15:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[14:0], mosi_bits[from + i]};
        return v;
    endfunction

    initial begin
        int rb, qb, rdb, csb, k;

        srst      = 1'b1;
        enable    = 1'b0;
        rx_full   = 1'b0;
        b_enable  = 1'b0;
        b_tx_data = 8'h80;
        b_tx_empty = 1'b1;
        b_rx_full = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_strobes", {tx_rd_en, rx_wr_en, rx_overflow}, 0);
        srst = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Single word 0xA5 in loopback.
        rb = rises; qb = rx_q.size(); rdb = rd_cnt; csb = cs_rises;
        push_tx(8'hA5);
        wait_done(qb + 1, "t1");
        chk("t1_sclk_pulses", rises - rb, 8);
        chk("t1_mosi_bits", mosi_seq(rb, 8), 16'h00A5);
        chk("t1_rx_count", rx_q.size() - qb, 1);
        chk("t1_rx_data", rx_q[qb], 8'hA5);
        chk("t1_rd_pulses", rd_cnt - rdb, 1);
        chk("t1_cs_release", {cs_rises - csb, 31'(cs_n)}, {32'd1, 31'd1});
        chk("t1_cs_lead", rise_cyc[rb] - cs_fall_cyc, 2);

        // Back-to-back 0x3C, 0xC3.
        rb = rises; qb = rx_q.size(); rdb = rd_cnt; csb = cs_rises;
        push_tx(8'h3C);
        push_tx(8'hC3);
        wait_done(qb + 2, "t2");
        chk("t2_sclk_pulses", rises - rb, 16);
        chk("t2_mosi_bits", mosi_seq(rb, 16), 16'h3CC3);
        chk("t2_rx_first", rx_q[qb], 8'h3C);
        chk("t2_rx_second", rx_q[qb + 1], 8'hC3);
        chk("t2_wr_spacing", wr_cyc[qb + 1] - wr_cyc[qb], 34);
        chk("t2_rd_pulses", rd_cnt - rdb, 2);
        chk("t2_cs_rises", cs_rises - csb, 1);

        // rx_full blocks start; rx_full at word end sets sticky overflow and blocks the next pop.
        qb = rx_q.size(); rdb = rd_cnt;
        rx_full = 1'b1;
        push_tx(8'h5A);
        repeat (10) @(negedge clk);
        chk("t4_no_pop_full", rd_cnt - rdb, 0);
        chk("t4_cs_idle_full", {cs_n, busy}, 2'b10);
        rb = rises;
        rx_full = 1'b0;
        k = 0;
        while (rises - rb < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        rx_full = 1'b1;
        push_tx(8'hA0);
        wait_done(qb + 1, "t4a");
        chk("t4_rx_data", rx_q[qb], 8'h5A);
        chk("t4_overflow", rx_overflow, 1);
        repeat (20) @(negedge clk);
        chk("t4_no_second_pop", rd_cnt - rdb, 1);
        chk("t4_held_idle", {cs_n, busy}, 2'b10);
        rx_full = 1'b0;
        wait_done(qb + 2, "t4b");
        chk("t4_rx_second", rx_q[qb + 1], 8'hA0);
        chk("t4_overflow_sticky", rx_overflow, 1);

        // Reset at bit 4 of a word.
        rb = rises; qb = rx_q.size();
        push_tx(8'h96);
        k = 0;
        while (rises - rb < 4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reached_bit4", rises - rb, 4);
        srst = 1'b1;
        #1;
        chk("t5_async_outputs", {cs_n, sclk, busy}, 3'b100);
        chk("t5_overflow_cleared", rx_overflow, 0);
        repeat (2) @(negedge clk);
        srst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_partial_push", rx_q.size() - qb, 0);
        rb = rises; rdb = rd_cnt;
        push_tx(8'h69);
        wait_done(qb + 1, "t5");
        chk("t5_restart_rx", rx_q[qb], 8'h69);
        chk("t5_restart_pulses", {rd_cnt - rdb, rises - rb}, {32'd1, 32'd8});

        // enable dropped mid-word: word completes, no further pop.
        qb = rx_q.size(); rdb = rd_cnt; rb = rises;
        push_tx(8'h11);
        push_tx(8'h22);
        k = 0;
        while (rises - rb < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        wait_done(qb + 1, "t6");
        repeat (40) @(negedge clk);
        chk("t6_rx_data", rx_q[qb], 8'h11);
        chk("t6_single_pop", rd_cnt - rdb, 1);
        chk("t6_stays_idle", {cs_n, busy, 32'(rx_q.size() - qb)}, {2'b10, 32'd1});
        enable = 1'b1;
        wait_done(qb + 2, "t6b");
        chk("t6_resume_rx", rx_q[qb + 1], 8'h22);
        chk("t6_bad_pops", bad_pop, 0);

        // LSB-first instance: tx 0x80, miso pattern 0x01.
        b_enable   = 1'b1;
        b_tx_empty = 1'b0;
        k = 0;
        while (b_rd_cnt == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        b_tx_empty = 1'b1;
        k = 0;
        while ((b_rx_cnt == 0 || b_busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t3_first_mosi", b_first, 0);
        chk("t3_mosi_bits", b_seq, 8'h01);
        chk("t3_rx_data", b_rx_last, 8'h01);
        chk("t3_counts", {b_rx_cnt, b_rd_cnt, b_rises}, {32'd1, 32'd1, 32'd8});
        chk("t3_end_state", {b_cs_n, b_sclk, b_busy}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
